// File: rtl/tff_toggle_gen.sv
// rtl/tff_toggle_gen.sv - programmable T-strobe generator for a downstream sync-reset TFF
// Optional q_mirror output (model of the TFF Q) is built when TOGGLE_MIRROR_EN is defined.
module tff_toggle_gen #(
  parameter int CNT_W   = 8,
  parameter int BURST_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic [CNT_W-1:0]   div,
  input  logic [BURST_W-1:0] burst,
  output logic               T,
  output logic               busy,
  output logic               done,
  output logic [BURST_W-1:0] pulses_sent
`ifdef TOGGLE_MIRROR_EN
  ,
  output logic               q_mirror
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   div_q, div_d;
  logic [BURST_W-1:0] burst_q, burst_d;
  logic [BURST_W-1:0] pulses_q, pulses_d;
  logic               t_q, t_d;
  logic [CNT_W-1:0]   div_eff;

  assign div_eff = (div == '0) ? CNT_W'(1) : div;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    div_d    = div_q;
    burst_d  = burst_q;
    pulses_d = pulses_q;
    t_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        // stop wins over start while idle
        if (start && !stop) begin
          div_d    = div_eff;
          burst_d  = burst;
          cnt_d    = div_eff - CNT_W'(1);
          pulses_d = '0;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        if (stop) begin
          state_d = S_IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          t_d      = 1'b1;
          cnt_d    = div_q - CNT_W'(1);
          pulses_d = pulses_q + BURST_W'(1);
          if (burst_q != '0 && pulses_d == burst_q) state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      div_q    <= '0;
      burst_q  <= '0;
      pulses_q <= '0;
      t_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      burst_q  <= burst_d;
      pulses_q <= pulses_d;
      t_q      <= t_d;
    end
  end

  assign T           = t_q;
  assign busy        = (state_q == S_RUN);
  assign done        = (state_q == S_DONE);
  assign pulses_sent = pulses_q;

`ifdef TOGGLE_MIRROR_EN
  logic mirror_q, mirror_d;

  // toggles exactly where the downstream TFF would see T high
  assign mirror_d = mirror_q ^ t_q;

  always_ff @(posedge clk) begin
    if (rst) mirror_q <= 1'b0;
    else     mirror_q <= mirror_d;
  end

  assign q_mirror = mirror_q;
`else
`endif

endmodule

// File: tb/tb_tff_toggle_gen.sv
// tb/tb_tff_toggle_gen.sv - scoreboard bench for tff_toggle_gen
// Expected T-pulse and done cycles are queued at start and matched as the DUT emits them.
module tb_tff_toggle_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [7:0] div = 8'd0;
  logic [7:0] burst = 8'd0;
  logic       T;
  logic       busy;
  logic       done;
  logic [7:0] pulses_sent;
`ifdef TOGGLE_MIRROR_EN
  logic       q_mirror;
  logic       tff_q;
`endif

  tff_toggle_gen #(.CNT_W(8), .BURST_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .stop        (stop),
    .div         (div),
    .burst       (burst),
    .T           (T),
    .busy        (busy),
    .done        (done),
    .pulses_sent (pulses_sent)
`ifdef TOGGLE_MIRROR_EN
    ,
    .q_mirror    (q_mirror)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int exp_t[$];
  int exp_done[$];
  int k;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0d expected=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // start a run sampled at the next edge and queue its expected pulses
  task automatic start_run(input int d, input int b, input int npush);
    int deff;
    deff  = (d == 0) ? 1 : d;
    div   = 8'(d);
    burst = 8'(b);
    start = 1'b1;
    step();
    start = 1'b0;
    k = cyc;
    for (int i = 1; i <= npush; i++) exp_t.push_back(k + i * deff);
    if (b != 0) exp_done.push_back(k + b * deff);
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 300 && done !== 1'b1; i++) step();
    check_eq(tag, int'(done), 1);
  endtask

  always @(negedge clk) begin
    if (T === 1'b1) begin
      if (exp_t.size() == 0) check_eq("t_spurious", int'(T), 0);
      else check_eq("t_cycle", cyc, exp_t.pop_front());
    end
    if (done === 1'b1) begin
      if (exp_done.size() == 0) check_eq("done_spurious", int'(done), 0);
      else check_eq("done_cycle", cyc, exp_done.pop_front());
    end
  end

`ifdef TOGGLE_MIRROR_EN
  always @(posedge clk) begin
    if (rst) tff_q <= 1'b0;
    else if (T) tff_q <= ~tff_q;
  end

  always @(negedge clk) begin
    if (cyc > 2) check_eq("q_mirror", int'(q_mirror), int'(tff_q));
  end
`endif

  initial begin
    // 1) reset and idle
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    check_eq("rst_T", int'(T), 0);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_done", int'(done), 0);
    check_eq("rst_pulses", int'(pulses_sent), 0);
    repeat (20) step();

    // 2) div=3 burst=4
    start_run(3, 4, 4);
    step();
    check_eq("run_busy", int'(busy), 1);
    wait_done("t2_done_seen");
    check_eq("t2_pulses", int'(pulses_sent), 4);
    check_eq("t2_T_with_done", int'(T), 1);
    check_eq("t2_busy_in_done", int'(busy), 0);
    step();
    check_eq("t2_done_1cyc", int'(done), 0);
    check_eq("t2_idle_busy", int'(busy), 0);
    check_eq("t2_T_low", int'(T), 0);
    check_eq("t2_pulses_hold", int'(pulses_sent), 4);
    repeat (5) step();

    // 3) div=0 burst=0, stop after 5 pulses
    start_run(0, 0, 5);
    repeat (5) step();
    check_eq("t3_pulses5", int'(pulses_sent), 5);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check_eq("t3_stop_T", int'(T), 0);
    check_eq("t3_stop_busy", int'(busy), 0);
    check_eq("t3_stop_done", int'(done), 0);
    check_eq("t3_stop_pulses", int'(pulses_sent), 5);
    repeat (5) step();
    check_eq("t3_pulses_hold", int'(pulses_sent), 5);

    // 4) reset mid-run
    start_run(4, 2, 2);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_t.delete();
    exp_done.delete();
    check_eq("t4_T", int'(T), 0);
    check_eq("t4_busy", int'(busy), 0);
    check_eq("t4_done", int'(done), 0);
    check_eq("t4_pulses", int'(pulses_sent), 0);
    repeat (15) step();
    start_run(3, 4, 4);
    wait_done("t4_restart_done");
    check_eq("t4_restart_pulses", int'(pulses_sent), 4);
    repeat (3) step();

    // 5) start+stop in idle, then ignored mid-run changes
    div = 8'd2;
    burst = 8'd1;
    start = 1'b1;
    stop = 1'b1;
    step();
    start = 1'b0;
    stop = 1'b0;
    check_eq("t5_stay_idle", int'(busy), 0);
    repeat (4) step();
    start_run(3, 2, 2);
    step();
    start = 1'b1;
    div = 8'd1;
    burst = 8'd1;
    step();
    start = 1'b0;
    wait_done("t5_done_seen");
    check_eq("t5_pulses", int'(pulses_sent), 2);
    repeat (8) step();

`ifdef TOGGLE_MIRROR_EN
    // 6) mirror against a real TFF
    start_run(2, 5, 5);
    wait_done("t6_done_seen");
    step();
    check_eq("t6_final_q", int'(q_mirror), 1);
    repeat (3) step();
`endif

    check_eq("exp_t_left", exp_t.size(), 0);
    check_eq("exp_done_left", exp_done.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
